// File: rtl/rng_health_packer_pkg.sv
// Shared definitions for the RNG health packer: byte width, default cutoffs and FSM encoding.
package rng_health_packer_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_WORD_BYTES     = 4;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_STARTUP_BYTES  = 64;
    localparam int DEF_RCT_CUTOFF     = 4;
    localparam int DEF_APT_WINDOW     = 64;
    localparam int DEF_APT_CUTOFF     = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STARTUP = 2'd1,
        ST_RUN     = 2'd2,
        ST_FAIL    = 2'd3
    } rng_state_e;

    function automatic logic is_active(input rng_state_e s);
        return (s == ST_STARTUP) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/rng_word_fifo.sv
// First-word-fall-through word FIFO with synchronous flush and occupancy output.
// DEPTH must be a power of 2 (at least 2) so the pointers wrap naturally.
module rng_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == LW'(DEPTH));
    assign level = count;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(wr_en) - LW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rng_health_packer.sv
// RCT/APT health tests on the NeoRNG byte stream, little-endian word packing and an output FIFO.
// Valid/ready: a word transfers on any cycle where word_valid_o && word_ready_i; word_o is stable until then.
module rng_health_packer
    import rng_health_packer_pkg::*;
#(
    parameter int WORD_BYTES    = DEF_WORD_BYTES,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int STARTUP_BYTES = DEF_STARTUP_BYTES,
    parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW    = DEF_APT_WINDOW,
    parameter int APT_CUTOFF    = DEF_APT_CUTOFF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_i,
    input  logic                           valid_i,
    input  logic [BYTE_W-1:0]              data_i,
    input  logic                           clear_fail_i,
    input  logic                           word_ready_i,
    output logic                           word_valid_o,
    output logic [BYTE_W*WORD_BYTES-1:0]   word_o,
    output logic                           health_fail_o,
    output logic [$clog2(FIFO_DEPTH):0]    level_o,
    output logic [15:0]                    drop_cnt_o
);

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int SU_W   = $clog2(STARTUP_BYTES + 1);
    localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int APT_W  = $clog2(APT_CUTOFF + 1);
    localparam int POS_W  = $clog2(APT_WINDOW + 1);

    rng_state_e         state, state_nxt;
    logic               active, accept, tests_clr, pack, push, flush, pop, drop;
    logic               rct_trip, apt_trip, trip;
    logic               fifo_full, fifo_empty;
    logic [BYTE_W-1:0]  last_byte, apt_ref;
    logic [RCT_W-1:0]   rct_cnt, rct_nxt;
    logic [APT_W-1:0]   apt_cnt;
    logic [POS_W-1:0]   apt_pos;
    logic [SU_W-1:0]    su_cnt;
    logic [IDX_W-1:0]   byte_idx;
    logic [WORD_W-1:0]  shift_word, word_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (enable_i) state_nxt = ST_STARTUP;
            ST_STARTUP: begin
                if (!enable_i)  state_nxt = ST_IDLE;
                else if (trip)  state_nxt = ST_FAIL;
                else if (accept && su_cnt == SU_W'(STARTUP_BYTES - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable_i)  state_nxt = ST_IDLE;
                else if (trip)  state_nxt = ST_FAIL;
            end
            ST_FAIL:    if (clear_fail_i) state_nxt = enable_i ? ST_STARTUP : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        active        = is_active(state);
        accept        = valid_i && active;
        tests_clr     = !active || !enable_i;
        flush         = active && enable_i && trip;
        pack          = (state == ST_RUN) && enable_i && accept && !trip;
        push          = pack && (byte_idx == IDX_W'(WORD_BYTES - 1));
        health_fail_o = (state == ST_FAIL);
    end

    // Trips are evaluated on the incoming byte so the offending byte never reaches the packer.
    always_comb begin
        rct_nxt  = (rct_cnt != '0 && data_i == last_byte) ? rct_cnt + 1'b1 : RCT_W'(1);
        rct_trip = accept && (rct_nxt == RCT_W'(RCT_CUTOFF));
        apt_trip = accept && (apt_pos != '0) && (data_i == apt_ref) &&
                   (apt_cnt + APT_W'(1) == APT_W'(APT_CUTOFF));
        trip     = rct_trip || apt_trip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_byte <= '0;
            rct_cnt   <= '0;
            apt_ref   <= '0;
            apt_cnt   <= '0;
            apt_pos   <= '0;
        end else if (tests_clr) begin
            last_byte <= '0;
            rct_cnt   <= '0;
            apt_ref   <= '0;
            apt_cnt   <= '0;
            apt_pos   <= '0;
        end else if (accept) begin
            last_byte <= data_i;
            rct_cnt   <= rct_nxt;
            if (apt_pos == '0) begin
                apt_ref <= data_i;
                apt_cnt <= APT_W'(1);
            end else if (data_i == apt_ref) begin
                apt_cnt <= apt_cnt + 1'b1;
            end
            apt_pos <= (apt_pos == POS_W'(APT_WINDOW - 1)) ? '0 : apt_pos + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                su_cnt <= '0;
        else if (state != ST_STARTUP || tests_clr) su_cnt <= '0;
        else if (accept)                        su_cnt <= su_cnt + 1'b1;
    end

    always_comb begin
        word_nxt = shift_word;
        word_nxt[byte_idx*BYTE_W +: BYTE_W] = data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_word <= '0;
            byte_idx   <= '0;
        end else if (state != ST_RUN || !enable_i) begin
            shift_word <= '0;
            byte_idx   <= '0;
        end else if (pack) begin
            shift_word <= push ? '0 : word_nxt;
            byte_idx   <= push ? '0 : byte_idx + 1'b1;
        end
    end

    assign word_valid_o = !fifo_empty;
    assign pop          = word_valid_o && word_ready_i;
    assign drop         = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               drop_cnt_o <= '0;
        else if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
    end

    rng_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (word_nxt),
        .rdata (word_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

endmodule

// File: tb/tb_rng_health_packer.sv
// Directed bench for rng_health_packer: startup, packing, RCT/APT trips, FIFO full/drop, disable and async reset.
module tb_rng_health_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        clear_fail_i;
    logic        word_ready_i;
    logic        word_valid_o;
    logic [31:0] word_o;
    logic        health_fail_o;
    logic [3:0]  level_o;
    logic [15:0] drop_cnt_o;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    rng_health_packer dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .valid_i       (valid_i),
        .data_i        (data_i),
        .clear_fail_i  (clear_fail_i),
        .word_ready_i  (word_ready_i),
        .word_valid_o  (word_valid_o),
        .word_o        (word_o),
        .health_fail_o (health_fail_o),
        .level_o       (level_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input logic [7:0] base);
        logic [7:0] b0, b1, b2, b3;
        b0 = base;
        b1 = base + 8'd1;
        b2 = base + 8'd2;
        b3 = base + 8'd3;
        return {b3, b2, b1, b0};
    endfunction

    // drivers: entered and left on a falling edge
    task automatic send_byte(input logic [7:0] b);
        valid_i = 1'b1;
        data_i  = b;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic startup_bytes();
        for (int i = 0; i < 64; i++) send_byte(8'(i));
    endtask

    task automatic clear_fail();
        clear_fail_i = 1'b1;
        @(negedge clk);
        clear_fail_i = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, {31'd0, word_valid_o}, 32'd1);
        check({tag, "_word"}, word_o, e);
        word_ready_i = 1'b1;
        @(negedge clk);
        word_ready_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        enable_i     = 1'b0;
        valid_i      = 1'b0;
        data_i       = 8'h00;
        clear_fail_i = 1'b0;
        word_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, word_valid_o}, 32'd0);
        check("rst_word", word_o, 32'd0);
        check("rst_fail", {31'd0, health_fail_o}, 32'd0);
        check("rst_level", {28'd0, level_o}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt_o}, 32'd0);

        // 1: startup discard, then first packed word
        enable_i = 1'b1;
        @(negedge clk);
        startup_bytes();
        check("su_level", {28'd0, level_o}, 32'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check("t1_partial_valid", {31'd0, word_valid_o}, 32'd0);
        send_byte(8'h04);
        check("t1_valid", {31'd0, word_valid_o}, 32'd1);
        check("t1_word", word_o, 32'h04030201);
        check("t1_level", {28'd0, level_o}, 32'd1);
        word_ready_i = 1'b1;
        @(negedge clk);
        word_ready_i = 1'b0;
        check("t1_pop_level", {28'd0, level_o}, 32'd0);

        // 2: RCT trip on four AA bytes flushes a queued word
        send_word(32'h08070605);
        check("t2_pre_level", {28'd0, level_o}, 32'd1);
        send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hAA);
        check("t2_three_fail", {31'd0, health_fail_o}, 32'd0);
        send_byte(8'hAA);
        check("t2_fail", {31'd0, health_fail_o}, 32'd1);
        check("t2_level", {28'd0, level_o}, 32'd0);
        check("t2_valid", {31'd0, word_valid_o}, 32'd0);
        send_word(32'h04030201);
        check("t2_ignored", {28'd0, level_o}, 32'd0);
        check("t2_sticky", {31'd0, health_fail_o}, 32'd1);
        clear_fail();
        check("t2_cleared", {31'd0, health_fail_o}, 32'd0);
        startup_bytes();
        check("t2_su_level", {28'd0, level_o}, 32'd0);
        send_word(32'h44332211);
        check("t2_word", word_o, 32'h44332211);
        check("t2_word_level", {28'd0, level_o}, 32'd1);

        // 3: APT trip; reference 11 already counted once, 11 more interleaved, 13th copy trips
        for (int k = 0; k < 11; k++) begin
            send_byte(8'h11);
            send_byte(8'(8'h50 + k));
        end
        check("t3_pre_fail", {31'd0, health_fail_o}, 32'd0);
        check("t3_pre_level", {28'd0, level_o}, 32'd6);
        check("t3_head", word_o, 32'h44332211);
        send_byte(8'h11);
        check("t3_fail", {31'd0, health_fail_o}, 32'd1);
        check("t3_level", {28'd0, level_o}, 32'd0);

        // 4: fill the FIFO, overflow once, then push with a simultaneous pop
        clear_fail();
        startup_bytes();
        for (int k = 0; k < 8; k++) send_word(mk_word(8'(8'h80 + 4 * k)));
        check("t4_full_level", {28'd0, level_o}, 32'd8);
        check("t4_full_drop", {16'd0, drop_cnt_o}, 32'd0);
        send_word(mk_word(8'hA0));
        check("t4_drop_level", {28'd0, level_o}, 32'd8);
        check("t4_drop_cnt", {16'd0, drop_cnt_o}, 32'd1);
        check("t4_head", word_o, 32'h83828180);
        send_byte(8'hA4); send_byte(8'hA5); send_byte(8'hA6);
        word_ready_i = 1'b1;
        send_byte(8'hA7);
        word_ready_i = 1'b0;
        check("t4_pp_level", {28'd0, level_o}, 32'd8);
        check("t4_pp_drop", {16'd0, drop_cnt_o}, 32'd1);
        for (int k = 1; k < 8; k++) exp_q.push_back(mk_word(8'(8'h80 + 4 * k)));
        exp_q.push_back(32'hA7A6A5A4);
        for (int k = 0; k < 8; k++) pop_check("t4_pop");
        check("t4_empty", {28'd0, level_o}, 32'd0);

        // 5: disable mid-word keeps the FIFO but drops the partial word
        send_word(32'hC3C2C1C0);
        send_word(32'hC7C6C5C4);
        send_byte(8'hC8); send_byte(8'hC9);
        enable_i = 1'b0;
        @(negedge clk);
        check("t5_level", {28'd0, level_o}, 32'd2);
        check("t5_fail", {31'd0, health_fail_o}, 32'd0);
        send_byte(8'hEE);
        check("t5_idle_ignore", {28'd0, level_o}, 32'd2);
        exp_q.push_back(32'hC3C2C1C0);
        pop_check("t5_pop0");
        enable_i = 1'b1;
        @(negedge clk);
        startup_bytes();
        send_word(32'hD3D2D1D0);
        check("t5_level2", {28'd0, level_o}, 32'd2);
        exp_q.push_back(32'hC7C6C5C4);
        exp_q.push_back(32'hD3D2D1D0);
        pop_check("t5_pop1");
        pop_check("t5_pop2");

        // 6: asynchronous reset mid-word with three words queued
        send_word(32'hE3E2E1E0);
        send_word(32'hE7E6E5E4);
        send_word(32'hEBEAE9E8);
        send_byte(8'hEC); send_byte(8'hED);
        check("t6_level", {28'd0, level_o}, 32'd3);
        check("t6_drop", {16'd0, drop_cnt_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, word_valid_o}, 32'd0);
        check("t6_rst_word", word_o, 32'd0);
        check("t6_rst_level", {28'd0, level_o}, 32'd0);
        check("t6_rst_drop", {16'd0, drop_cnt_o}, 32'd0);
        check("t6_rst_fail", {31'd0, health_fail_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_level", {28'd0, level_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
